// File: rtl/conv_row_accumulator_if.sv
// Bundles the product stream, partial-sum buffer port and pixel stream of the
// row accumulator. The slave modport is the accumulator's view.
`ifndef KERNEL_HEIGHT
`define KERNEL_HEIGHT 3
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 3
`endif
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 8
`endif

interface conv_row_accumulator_if #(
  parameter int KERNEL_HEIGHT   = `KERNEL_HEIGHT,
  parameter int INPUT_WIDTH_LOG = `INPUT_WIDTH_LOG,
  parameter int OUT_BIN_LEN     = `OUT_BIN_LEN
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [KERNEL_HEIGHT-1:0][OUT_BIN_LEN-1:0] products;
  logic [KERNEL_HEIGHT-1:0][OUT_BIN_LEN-1:0] fetch_vals;
  logic [KERNEL_HEIGHT-1:0][OUT_BIN_LEN-1:0] store_vals;
  logic [INPUT_WIDTH_LOG-1:0]                buf_width_index;
  logic                                      buf_enable;
  logic                                      buf_clear;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [OUT_BIN_LEN-1:0]                    out_data;
  logic                                      out_last;

  modport slave (
    input  in_valid, products, fetch_vals, out_ready,
    output in_ready, store_vals, buf_width_index, buf_enable, buf_clear,
           out_valid, out_data, out_last
  );

  modport master (
    output in_valid, products, fetch_vals, out_ready,
    input  in_ready, store_vals, buf_width_index, buf_enable, buf_clear,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_row_accumulator.sv
// Adds each column's per-row products to the buffered partial sums, writes them
// back, and streams finished pixels once a full kernel window has been summed.
`ifndef KERNEL_HEIGHT
`define KERNEL_HEIGHT 3
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 3
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 5
`endif
`ifndef INPUT_WIDTH_LOG
`define INPUT_WIDTH_LOG 3
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 5
`endif
`ifndef OUT_BIN_LEN
`define OUT_BIN_LEN 8
`endif

module conv_row_accumulator #(
  parameter int KERNEL_HEIGHT   = `KERNEL_HEIGHT,
  parameter int KERNEL_WIDTH    = `KERNEL_WIDTH,
  parameter int INPUT_WIDTH     = `INPUT_WIDTH,
  parameter int INPUT_WIDTH_LOG = `INPUT_WIDTH_LOG,
  parameter int INPUT_HEIGHT    = `INPUT_HEIGHT,
  parameter int OUT_BIN_LEN     = `OUT_BIN_LEN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  conv_row_accumulator_if.slave   bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int ROW_W = $clog2(INPUT_HEIGHT + 1);
  localparam logic [INPUT_WIDTH_LOG-1:0] COL_FIRST = INPUT_WIDTH_LOG'(KERNEL_WIDTH - 1);
  localparam logic [INPUT_WIDTH_LOG-1:0] COL_LAST  = INPUT_WIDTH_LOG'(INPUT_WIDTH - 1);
  localparam logic [ROW_W-1:0]           ROW_FIRST = ROW_W'(KERNEL_HEIGHT - 1);
  localparam logic [ROW_W-1:0]           ROW_LAST  = ROW_W'(INPUT_HEIGHT - 1);
  localparam logic [OUT_BIN_LEN-1:0]     SUM_MAX   = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [INPUT_WIDTH_LOG-1:0] col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUT_BIN_LEN-1:0]     out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic                       overflow_q, overflow_d;
  logic                       done_q, done_d;

  logic [KERNEL_HEIGHT-1:0][OUT_BIN_LEN-1:0] sum;
  logic [KERNEL_HEIGHT-1:0]                  lane_ovf;
  logic in_ready, accept, col_in_window, row_in_window, emit, col_end, row_end;

  // Returns {saturated, value}; the carry out of the widened add is the overflow.
  function automatic logic [OUT_BIN_LEN:0] sat_add(input logic [OUT_BIN_LEN-1:0] a,
                                                   input logic [OUT_BIN_LEN-1:0] b);
    logic [OUT_BIN_LEN:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[OUT_BIN_LEN]) return {1'b1, SUM_MAX};
    return s;
  endfunction

  always_comb begin : lane_sum
    logic [OUT_BIN_LEN:0] t;
    t        = '0;
    sum      = '0;
    lane_ovf = '0;
    for (int i = 0; i < KERNEL_HEIGHT; i++) begin
      t           = sat_add(bus.fetch_vals[i], bus.products[i]);
      sum[i]      = t[OUT_BIN_LEN-1:0];
      lane_ovf[i] = t[OUT_BIN_LEN];
    end
  end

  assign in_ready      = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign col_in_window = col_q >= COL_FIRST;
  assign row_in_window = row_q >= ROW_FIRST;
  assign emit          = accept && col_in_window && row_in_window;
  assign col_end       = col_q == COL_LAST;
  assign row_end       = row_q == ROW_LAST;

  assign bus.in_ready        = in_ready;
  assign bus.store_vals      = sum;
  assign bus.buf_width_index = col_q;
  assign bus.buf_enable      = accept && col_in_window;
  assign bus.buf_clear       = state_q == CLEAR;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_last        = out_last_q;
  assign busy                = state_q != IDLE;
  assign done                = done_q;
  assign overflow            = overflow_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CLEAR;
          overflow_d = 1'b0;
        end
      end
      CLEAR: begin
        col_d   = '0;
        row_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          if (|lane_ovf) overflow_d = 1'b1;
          // A freshly loaded pixel overrides the handshake clear above.
          if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = sum[KERNEL_HEIGHT-1];
            out_last_d  = row_end && col_end;
          end
          if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_end) state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && bus.out_ready && out_last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered boundary: control state, counters and the output pixel.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_row_accumulator.sv
// Randomized scoreboard bench for conv_row_accumulator with a shifting
// partial-sum buffer stub and a per-window saturating-sum reference.
module tb_conv_row_accumulator;
  localparam int KH  = 3;
  localparam int KW  = 3;
  localparam int W   = 5;
  localparam int IWL = 3;
  localparam int H   = 5;
  localparam int OBL = 8;

  typedef struct {
    logic [OBL-1:0] d;
    logic           l;
  } exp_t;

  logic clock, reset, start, busy, done, overflow;
  conv_row_accumulator_if #(.KERNEL_HEIGHT(KH), .INPUT_WIDTH_LOG(IWL), .OUT_BIN_LEN(OBL)) bus();

  conv_row_accumulator #(
    .KERNEL_HEIGHT(KH), .KERNEL_WIDTH(KW), .INPUT_WIDTH(W),
    .INPUT_WIDTH_LOG(IWL), .INPUT_HEIGHT(H), .OUT_BIN_LEN(OBL)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  // Partial-sum buffer: lane k of a column reads back what lane k-1 stored one row earlier.
  logic [OBL-1:0] mem [W][KH];
  always @(posedge clock) begin
    if (reset || bus.buf_clear) begin
      for (int i = 0; i < W; i++)
        for (int k = 0; k < KH; k++) mem[i][k] <= '0;
    end else if (bus.buf_enable) begin
      for (int k = 0; k < KH; k++) mem[bus.buf_width_index][k] <= bus.store_vals[k];
    end
  end

  always_comb begin
    bus.fetch_vals = '0;
    for (int k = 1; k < KH; k++)
      if (int'(bus.buf_width_index) < W) bus.fetch_vals[k] = mem[bus.buf_width_index][k-1];
  end

  // Consumer ready: held high, randomized, or forced low for a window.
  int cyc = 0;
  int bp_until = 0;
  bit rnd_ready = 1'b0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc < bp_until)  bus.out_ready = 1'b0;
      else if (rnd_ready)  bus.out_ready = 1'($urandom_range(0, 1));
      else                 bus.out_ready = 1'b1;
    end
  end

  // Monitor: pixel scoreboard, hold-under-backpressure, done timing, clear count.
  int   clears = 0;
  bit   done_exp, hold_v, hold_l, hs;
  logic [OBL-1:0] hold_d;
  exp_t em;
  initial begin
    done_exp = 0; hold_v = 0; hold_l = 0; hold_d = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        done_exp = 0;
        hold_v   = 0;
      end else begin
        chk("done_pulse", 32'(done), 32'(done_exp));
        if (hold_v) begin
          chk("hold_valid", 32'(bus.out_valid), 1);
          chk("hold_data", 32'(bus.out_data), 32'(hold_d));
          chk("hold_last", 32'(bus.out_last), 32'(hold_l));
        end
        if (bus.out_valid && !bus.out_ready) chk("bp_in_ready", 32'(bus.in_ready), 0);
        if (bus.buf_clear) clears++;
        hs = bus.out_valid && bus.out_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_pixel: got data %0d, expected no pixel", bus.out_data);
          end else begin
            em = exp_q.pop_front();
            chk("pixel_data", 32'(bus.out_data), 32'(em.d));
            chk("pixel_last", 32'(bus.out_last), 32'(em.l));
          end
        end
        done_exp = hs && bus.out_last;
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_d   = bus.out_data;
        hold_l   = bus.out_last;
      end
    end
  end

  // Reference: each window pixel is the saturating running sum down its diagonal of lanes.
  logic [OBL-1:0] P [H][W][KH];
  int  exp_pix [H][W];
  bit  exp_ovf;

  task automatic make_frame(input int mode);
    int v [H][KH];
    int prev;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < KH; k++)
          case (mode)
            0:       P[r][c][k] = 8'd1;
            1:       P[r][c][k] = 8'd200;
            2:       P[r][c][k] = 8'($urandom_range(0, 80));
            default: P[r][c][k] = 8'($urandom_range(0, 255));
          endcase
    exp_ovf = 0;
    for (int c = KW - 1; c < W; c++)
      for (int r = 0; r < H; r++) begin
        for (int k = 0; k < KH; k++) begin
          prev = (r == 0 || k == 0) ? 0 : v[r-1][k-1];
          v[r][k] = prev + int'(P[r][c][k]);
          if (v[r][k] > 255) begin
            v[r][k] = 255;
            exp_ovf = 1;
          end
        end
        exp_pix[r][c] = v[r][KH-1];
      end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready), 0);
    chk({tag, "_buf_enable"}, 32'(bus.buf_enable), 0);
    chk({tag, "_buf_clear"},  32'(bus.buf_clear), 0);
    chk({tag, "_out_valid"},  32'(bus.out_valid), 0);
    chk({tag, "_out_last"},   32'(bus.out_last), 0);
    chk({tag, "_busy"},       32'(busy), 0);
    chk({tag, "_done"},       32'(done), 0);
    chk({tag, "_overflow"},   32'(overflow), 0);
    chk({tag, "_out_data"},   32'(bus.out_data), 0);
    chk({tag, "_width_idx"},  32'(bus.buf_width_index), 0);
  endtask

  task automatic run_frame(input int mode, input bit gaps, input int bp_at, input int abort_at);
    int nacc, budget, clr0;
    bit acc, lat;
    exp_t e;
    make_frame(mode);
    clr0 = clears;
    @(posedge clock); #1;
    start = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clock);
    chk("clear_pulse", 32'(bus.buf_clear), 1);
    chk("clear_busy", 32'(busy), 1);
    chk("start_clears_ovf", 32'(overflow), 0);
    chk("clear_in_ready", 32'(bus.in_ready), 0);
    nacc = 0;
    lat  = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int k = 0; k < KH; k++) bus.products[k] = P[r][c][k];
        bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        budget = 0;
        forever begin
          @(negedge clock);
          if (lat) begin
            chk("emit_latency", 32'(bus.out_valid), 1);
            lat = 0;
          end
          acc = bus.in_valid && bus.in_ready;
          if (acc) begin
            chk("width_index", 32'(bus.buf_width_index), 32'(c));
            chk("buf_enable", 32'(bus.buf_enable), 32'(c >= KW - 1));
          end
          @(posedge clock); #1;
          start = 1'b0;
          if (acc) break;
          budget++;
          if (budget > 500) begin
            $display("FAIL accept_timeout: got no accept in 500 cycles, expected beat %0d", nacc);
            $fatal(1, "accept wait expired");
          end
          if (gaps) bus.in_valid = ($urandom_range(0, 3) != 0);
        end
        nacc++;
        if (r >= KH - 1 && c >= KW - 1) begin
          e.d = 8'(exp_pix[r][c]);
          e.l = (r == H - 1) && (c == W - 1);
          exp_q.push_back(e);
          lat = 1;
        end
        if (nacc == 3) start = 1'b1;
        if (nacc == bp_at) bp_until = cyc + 5;
        if (nacc == abort_at) begin
          reset = 1'b1;
          bus.in_valid = 1'b0;
          exp_q.delete();
          @(posedge clock);
          @(negedge clock);
          check_reset_vals("midrst");
          @(posedge clock); #1;
          reset = 1'b0;
          return;
        end
      end
    end
    bus.in_valid = 1'b1;
    budget = 0;
    forever begin
      @(negedge clock);
      if (lat) begin
        chk("emit_latency", 32'(bus.out_valid), 1);
        lat = 0;
      end
      if (done) break;
      chk("drain_in_ready", 32'(bus.in_ready), 0);
      budget++;
      if (budget > 200) begin
        $display("FAIL done_timeout: got no done in 200 cycles, expected a done pulse");
        $fatal(1, "done wait expired");
      end
    end
    chk("end_busy", 32'(busy), 0);
    chk("idle_in_ready", 32'(bus.in_ready), 0);
    chk("end_overflow", 32'(overflow), 32'(exp_ovf));
    chk("clear_count", 32'(clears - clr0), 1);
    chk("pixels_left", 32'(exp_q.size()), 0);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.products = '0;
    repeat (2) begin
      @(posedge clock); #1;
      start = 1'($urandom_range(0, 1));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.products = (KH * OBL)'($urandom);
    end
    @(negedge clock);
    check_reset_vals("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("idle_ignore_in_ready", 32'(bus.in_ready), 0);
      chk("idle_ignore_enable", 32'(bus.buf_enable), 0);
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;

    run_frame(0, 1'b0, -1, -1);   // all-ones frame, no stalls
    run_frame(2, 1'b0, 14, -1);   // consumer stalls mid-frame
    run_frame(1, 1'b0, -1, -1);   // saturating products
    run_frame(2, 1'b0, -1, -1);   // start after saturation clears overflow
    run_frame(2, 1'b0, -1, 7);    // reset after 7 accepts
    run_frame(2, 1'b0, -1, -1);
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(3, 1'b1, -1, -1);
    rnd_ready = 1'b0;
    repeat (3) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by 500000, expected finish");
    $fatal(1, "global time limit");
  end
endmodule
